// File: rtl/vga_line_prefetch_if.sv
// Memory-controller command and read-FIFO port used by vga_line_prefetch.
// master = the prefetcher, slave = the memory controller side.
interface vga_line_prefetch_if;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_empty;
  logic        mem_rd_error;

  modport master (
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    input  mem_cmd_full, mem_rd_data, mem_rd_empty, mem_rd_error
  );

  modport slave (
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    output mem_cmd_full, mem_rd_data, mem_rd_empty, mem_rd_error
  );
endinterface

// File: rtl/vga_line_prefetch.sv
// Row prefetcher: fetches one 256-byte framebuffer row per screen line into a two-bank line RAM.
// Define VGA_PREFETCH_ERR_EN to honour mem_rd_error (sticky fetch_err plus an ERROR drain state).
module vga_line_prefetch #(
  parameter logic [29:0] BASE_ADDR = 30'h0000_0000,
  parameter int unsigned ROWS      = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       calib_done,
  input  logic       frame_start,
  input  logic       line_advance,
  input  logic [7:0] rd_x,
  output logic [7:0] rd_rgb,
  output logic       underrun,
  output logic       fetch_err,
  vga_line_prefetch_if.master mem
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, READY, ERROR} state_t;

  state_t      state, state_next;
  logic        front;
  logic        back;
  logic [1:0]  bank_valid;
  logic [7:0]  row;
  logic [7:0]  next_row;
  logic        burst;
  logic [4:0]  word_cnt;
  logic        discard;
  logic [29:0] row_addr;
  logic [31:0] line_ram [0:127];
  logic [31:0] rd_word;

  logic issue, rd_fire, last_word, rd_err;
  logic swap_ready, late_evt, fetch_done, late_swap;

  assign back     = ~front;
  assign next_row = (row == 8'(ROWS - 1)) ? 8'd0 : row + 8'd1;
  assign row_addr = BASE_ADDR + {14'd0, row, 8'd0} + {22'd0, burst, 7'd0};

`ifdef VGA_PREFETCH_ERR_EN
  assign rd_err = (state == DRAIN) && mem.mem_rd_error;
`else
  logic unused_rd_error;
  assign unused_rd_error = mem.mem_rd_error;
  assign rd_err          = 1'b0;
`endif

  assign issue      = (state == ISSUE) && calib_done && !mem.mem_cmd_full;
  assign rd_fire    = ((state == DRAIN) || (state == ERROR)) && !mem.mem_rd_empty;
  assign last_word  = (state == DRAIN) && rd_fire && (word_cnt == 5'd31) && !rd_err;
  assign swap_ready = line_advance && !frame_start && (state == READY);
  assign late_evt   = line_advance && !frame_start && (state != READY);
  assign fetch_done = last_word && burst && !discard && !frame_start;
  // A row that completes while nothing valid is on screen goes straight to the front.
  assign late_swap  = fetch_done && (!bank_valid[front] || late_evt);

  assign mem.mem_cmd_en        = issue;
  assign mem.mem_cmd_instr     = issue ? 3'b001 : 3'b000;
  assign mem.mem_cmd_bl        = issue ? 6'd31 : 6'd0;
  assign mem.mem_cmd_byte_addr = issue ? row_addr : 30'd0;
  assign mem.mem_rd_en         = rd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (!frame_start && calib_done && !bank_valid[back]) state_next = ISSUE;
      ISSUE: begin
        if (issue)            state_next = DRAIN;
        else if (frame_start) state_next = IDLE;
      end
      DRAIN: begin
        if (rd_err) state_next = ERROR;
        else if (last_word) begin
          if (discard || frame_start) state_next = IDLE;
          else if (!burst)            state_next = ISSUE;
          else if (late_swap)         state_next = IDLE;
          else                        state_next = READY;
        end
      end
      READY: if (frame_start || swap_ready) state_next = IDLE;
      ERROR: if (frame_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A burst already issued must drain fully; discard marks it so its data never becomes visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front      <= 1'b0;
      bank_valid <= 2'b00;
      row        <= 8'd0;
      burst      <= 1'b0;
      word_cnt   <= 5'd0;
      discard    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      discard <= (state_next == DRAIN) && (discard || frame_start);
      if (state != DRAIN) word_cnt <= 5'd0;
      else if (rd_fire)   word_cnt <= word_cnt + 5'd1;
      if (last_word && (state_next == ISSUE))              burst <= 1'b1;
      else if ((state_next != ISSUE) && (state_next != DRAIN)) burst <= 1'b0;
      if (frame_start) begin
        underrun   <= 1'b0;
        bank_valid <= 2'b00;
        row        <= 8'd0;
      end else begin
        if (late_evt) begin
          underrun          <= 1'b1;
          bank_valid[front] <= 1'b0;
        end
        if (rd_err) bank_valid[back] <= 1'b0;
        if (swap_ready) begin
          front             <= back;
          bank_valid[front] <= 1'b0;
          row               <= next_row;
        end else if (fetch_done) begin
          bank_valid[back] <= 1'b1;
          if (late_swap) begin
            front             <= back;
            bank_valid[front] <= 1'b0;
            row               <= next_row;
          end
        end
      end
    end
  end

`ifdef VGA_PREFETCH_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fetch_err <= 1'b0;
    else if (rd_err)      fetch_err <= 1'b1;
    else if (frame_start) fetch_err <= 1'b0;
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if ((state == DRAIN) && rd_fire) line_ram[{back, burst, word_cnt}] <= mem.mem_rd_data;
  end

  // Pixel x lives in word x[7:2], little-endian byte x[1:0].
  assign rd_word = line_ram[{front, rd_x[7:2]}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_rgb <= 8'h00;
    else     rd_rgb <= bank_valid[front] ? rd_word[{rd_x[1:0], 3'b000} +: 8] : 8'h00;
  end
endmodule

// File: tb/tb_vga_line_prefetch.sv
// Scoreboard bench for vga_line_prefetch driven by a FIFO-style memory controller model.
// Commands and pixels are predicted into queues; monitors pop and compare as the DUT presents them.
`timescale 1ns/1ps
module tb_vga_line_prefetch;
  localparam logic [29:0] BASE = 30'h0010_0000;
  localparam int ROWS = 6;
  localparam int LAT  = 20;

  typedef struct {
    logic [31:0] data;
    int          ready;
    bit          err;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       calib_done;
  logic       frame_start;
  logic       line_advance;
  logic [7:0] rd_x;
  logic [7:0] rd_rgb;
  logic       underrun;
  logic       fetch_err;

  vga_line_prefetch_if mem();

  vga_line_prefetch #(.BASE_ADDR(BASE), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done), .frame_start(frame_start),
    .line_advance(line_advance), .rd_x(rd_x), .rd_rgb(rd_rgb),
    .underrun(underrun), .fetch_err(fetch_err), .mem(mem)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          cmd_count = 0;
  int          err_burst = -1;
  bit          stall    = 1'b0;
  bit          pix_req  = 1'b0;
  word_t       rdq[$];
  logic [29:0] exp_cmd[$];
  logic [7:0]  exp_pix[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Row r, pixel x holds (x + 17*r) mod 256, so row 0 reads back as 0x03020100, 0x07060504, ...
  function automatic logic [7:0] pix(input int r, input int x);
    int v;
    v = x + r * 17;
    return v[7:0];
  endfunction

  function automatic logic [29:0] burst_addr(input int r, input int b);
    return BASE + 30'(r * 256 + b * 128);
  endfunction

  task automatic push_row(input int r);
    exp_cmd.push_back(burst_addr(r, 0));
    exp_cmd.push_back(burst_addr(r, 1));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int x, input logic [7:0] exp);
    rd_x    = 8'(x);
    pix_req = 1'b1;
    exp_pix.push_back(exp);
    tick(1);
    pix_req = 1'b0;
  endtask

  // Memory controller: handshakes sampled mid-cycle, FIFO updated just after the edge.
  initial begin : mem_model
    logic        cf, rf, cfull, ccal;
    logic [29:0] ca, off;
    logic [5:0]  cb;
    logic [2:0]  ci;
    logic [31:0] w;
    int          idx, r, bx;
    mem.mem_rd_empty = 1'b1;
    mem.mem_rd_data  = 32'd0;
    mem.mem_rd_error = 1'b0;
    forever begin
      @(negedge clk);
      cf    = mem.mem_cmd_en;
      ca    = mem.mem_cmd_byte_addr;
      cb    = mem.mem_cmd_bl;
      ci    = mem.mem_cmd_instr;
      cfull = mem.mem_cmd_full;
      ccal  = calib_done;
      rf    = mem.mem_rd_en && !mem.mem_rd_empty;
      @(posedge clk);
      #1;
      cyc++;
      if (rf && (rdq.size() > 0)) void'(rdq.pop_front());
      if (cf) begin
        idx = cmd_count;
        cmd_count++;
        check_output("cmd_full_calib", {30'd0, cfull, ccal}, 32'd1);
        check_output("cmd_instr", {29'd0, ci}, 32'd1);
        check_output("cmd_bl", {26'd0, cb}, 32'd31);
        if (exp_cmd.size() == 0) check_output("cmd_unexpected", {2'b00, ca}, 32'hFFFF_FFFF);
        else check_output("cmd_addr", {2'b00, ca}, {2'b00, exp_cmd.pop_front()});
        off = ca - BASE;
        r   = int'(off[29:8]);
        bx  = int'(off[7:0]);
        for (int k = 0; k < 32; k++) begin
          for (int i = 0; i < 4; i++) w[8*i +: 8] = pix(r, bx + 4 * k + i);
          rdq.push_back('{data: w, ready: cyc + LAT, err: (idx == err_burst) && (k == 7)});
        end
      end
      mem.mem_rd_empty = (rdq.size() == 0) || stall || (rdq[0].ready > cyc);
      mem.mem_rd_data  = (rdq.size() == 0) ? 32'd0 : rdq[0].data;
      mem.mem_rd_error = !mem.mem_rd_empty && rdq[0].err;
    end
  end

  // Pixel monitor: a request present at an edge is answered on rd_rgb after that edge.
  initial begin : pix_monitor
    bit seen;
    forever begin
      @(posedge clk);
      seen = pix_req;
      @(negedge clk);
      if (seen) begin
        if (exp_pix.size() == 0) check_output("pix_unexpected", {24'd0, rd_rgb}, 32'hFFFF_FFFF);
        else check_output("rd_rgb", {24'd0, rd_rgb}, {24'd0, exp_pix.pop_front()});
      end
    end
  end

  initial begin : stimulus
    int c0;
    rst = 1'b1; calib_done = 1'b0; frame_start = 1'b0; line_advance = 1'b0;
    rd_x = 8'd0; mem.mem_cmd_full = 1'b0;
    tick(4);
    check_output("rst_rd_rgb", {24'd0, rd_rgb}, 32'd0);
    check_output("rst_underrun", {31'd0, underrun}, 32'd0);
    check_output("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    check_output("rst_cmd_en", {31'd0, mem.mem_cmd_en}, 32'd0);
    check_output("rst_rd_en", {31'd0, mem.mem_rd_en}, 32'd0);
    rst = 1'b0;
    tick(2);

    // No commands while calibration is pending.
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(50);
    check_output("calib_hold_cmds", 32'(cmd_count), 32'd0);
    push_row(0); push_row(1);
    calib_done = 1'b1;
    tick(300);
    check_output("initial_cmds", 32'(cmd_count), 32'd4);
    for (int x = 0; x < 256; x++) apply_stimulus(x, pix(0, x));

    // Steady state: swaps one edge after line_advance, row index wraps after ROWS-1.
    for (int k = 1; k <= 7; k++) begin
      push_row((k + 1) % ROWS);
      line_advance = 1'b1;
      apply_stimulus(77, pix((k - 1) % ROWS, 77));
      line_advance = 1'b0;
      apply_stimulus(77, pix(k % ROWS, 77));
      apply_stimulus(255, pix(k % ROWS, 255));
      tick(297);
    end
    check_output("steady_underrun", {31'd0, underrun}, 32'd0);

    // Underrun with a stalled read FIFO, then late swap.
    push_row(0); push_row(1);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(300);
    apply_stimulus(5, pix(0, 5));
    push_row(2);
    line_advance = 1'b1;
    apply_stimulus(6, pix(0, 6));
    line_advance = 1'b0;
    stall = 1'b1;
    apply_stimulus(6, pix(1, 6));
    tick(100);
    line_advance = 1'b1; tick(1); line_advance = 1'b0;
    check_output("underrun_set", {31'd0, underrun}, 32'd1);
    apply_stimulus(10, 8'h00);
    stall = 1'b0;
    push_row(3);
    tick(300);
    apply_stimulus(100, pix(2, 100));
    apply_stimulus(255, pix(2, 255));
    check_output("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Command backpressure across a restart.
    push_row(0); push_row(1);
    c0 = cmd_count;
    mem.mem_cmd_full = 1'b1;
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    check_output("underrun_cleared", {31'd0, underrun}, 32'd0);
    tick(9);
    check_output("full_hold_cmds", 32'(cmd_count), 32'(c0));
    mem.mem_cmd_full = 1'b0;
    tick(300);
    check_output("full_release_cmds", 32'(cmd_count), 32'(c0 + 4));
    apply_stimulus(200, pix(0, 200));

    // frame_start and line_advance together in mid-drain: burst drains, then restart at row 0.
    c0 = cmd_count;
    exp_cmd.push_back(burst_addr(2, 0));
    line_advance = 1'b1; tick(1); line_advance = 1'b0;
    tick(33);
    frame_start = 1'b1; line_advance = 1'b1; tick(1);
    frame_start = 1'b0; line_advance = 1'b0;
    push_row(0); push_row(1);
    tick(300);
    check_output("collision_cmds", 32'(cmd_count), 32'(c0 + 5));
    check_output("collision_underrun", {31'd0, underrun}, 32'd0);
    apply_stimulus(3, pix(0, 3));
    apply_stimulus(128, pix(0, 128));

`ifdef VGA_PREFETCH_ERR_EN
    // Read error on word 7: sticky flag, FIFO drained, no further commands until frame_start.
    err_burst = cmd_count;
    exp_cmd.push_back(burst_addr(2, 0));
    line_advance = 1'b1; tick(1); line_advance = 1'b0;
    tick(150);
    check_output("fetch_err_set", {31'd0, fetch_err}, 32'd1);
    check_output("fifo_drained", 32'(rdq.size()), 32'd0);
    apply_stimulus(40, pix(1, 40));
    push_row(0); push_row(1);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    check_output("fetch_err_cleared", {31'd0, fetch_err}, 32'd0);
    tick(300);
    apply_stimulus(9, pix(0, 9));
`else
    // Without the error option mem_rd_error is ignored.
    err_burst = cmd_count;
    push_row(2);
    line_advance = 1'b1; tick(1); line_advance = 1'b0;
    tick(150);
    check_output("fetch_err_tied", {31'd0, fetch_err}, 32'd0);
    push_row(3);
    line_advance = 1'b1; tick(1); line_advance = 1'b0;
    apply_stimulus(29, pix(2, 29));
    tick(300);
`endif
    tick(5);
    check_output("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check_output("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
